// File: rtl/ov7670_pkg.sv
// Shared OV7670 definitions: SCCB write address, table markers and sequencer states.
package ov7670_pkg;

  localparam logic [7:0]  OV7670_WRITE_ID = 8'h42;
  localparam logic [15:0] CFG_END         = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY       = 16'hFFF0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_DELAY,
    ST_DONE
  } cfg_state_t;

endpackage

// File: rtl/ov7670_reg_rom.sv
// Synchronous-read register table, one-cycle latency. TABLE_SEL 0 is the camera
// bring-up list; 1..3 are small tables used for board bring-up and regression.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 256,
  parameter int unsigned TABLE_SEL = 0,
  localparam int unsigned ADDR_W   = $clog2(ROM_DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       data
);

  function automatic logic [15:0] word_at(input int unsigned a);
    logic [15:0] w;
    w = CFG_END;
    case (TABLE_SEL)
      1: case (a)
           0:       w = 16'h1280;
           1:       w = 16'h1204;
           default: w = CFG_END;
         endcase
      2: case (a)
           0:       w = 16'h1280;
           1:       w = CFG_DELAY;
           2:       w = 16'h1100;
           default: w = CFG_END;
         endcase
      3: case (a)
           0:       w = 16'h1280;
           1:       w = 16'h1204;
           2:       w = 16'h1100;
           default: w = 16'h1300;
         endcase
      default: case (a)
           0:       w = 16'h1280;  // COM7 soft reset, needs the following pause
           1:       w = CFG_DELAY;
           2:       w = 16'h1204;
           3:       w = 16'h1100;
           4:       w = 16'h0C00;
           5:       w = 16'h3E00;
           6:       w = 16'h8C00;
           7:       w = 16'h0400;
           8:       w = 16'h40D0;
           9:       w = 16'h3A04;
           10:      w = 16'h1418;
           11:      w = 16'h4FB3;
           12:      w = 16'h50B3;
           13:      w = 16'h5100;
           14:      w = 16'h523D;
           15:      w = 16'h53A7;
           16:      w = 16'h54E4;
           17:      w = 16'h589E;
           18:      w = 16'h3DC0;
           19:      w = 16'h1714;
           20:      w = 16'h1802;
           21:      w = 16'h3280;
           22:      w = 16'h1903;
           23:      w = 16'h1A7B;
           24:      w = 16'h030A;
           25:      w = 16'h0F41;
           26:      w = 16'h1E00;
           27:      w = 16'h330B;
           28:      w = 16'h3C78;
           29:      w = 16'h6900;
           30:      w = 16'h7400;
           31:      w = 16'hB084;
           32:      w = 16'hB10C;
           33:      w = 16'hB20E;
           34:      w = 16'hB380;
           default: w = CFG_END;
         endcase
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    data <= word_at(32'(addr));
  end

endmodule

// File: rtl/ov7670_config_ctrl.sv
// OV7670 configuration sequencer: walks the register table, hands each write to
// the SCCB sender via send/taken, honours table pauses and flags completion.
module ov7670_config_ctrl
  import ov7670_pkg::*;
#(
  parameter int unsigned ROM_DEPTH    = 256,
  parameter int unsigned DELAY_CYCLES = 25000,
  parameter logic [7:0]  CAM_ID       = OV7670_WRITE_ID,
  parameter int unsigned TABLE_SEL    = 0,
  localparam int unsigned ADDR_W      = $clog2(ROM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              resend,
  input  logic              taken,
  output logic              send,
  output logic [7:0]        id,
  output logic [7:0]        register,
  output logic [7:0]        value,
  output logic              config_done,
  output logic [ADDR_W-1:0] entry_idx
);

  localparam int unsigned CNT_W = ($clog2(DELAY_CYCLES) > 16) ? $clog2(DELAY_CYCLES) : 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [CNT_W-1:0]  DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);

  cfg_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              send_q, send_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic              done_q, done_d;
  logic              advance;
  logic [15:0]       rom_data;

  ov7670_reg_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .TABLE_SEL (TABLE_SEL)
  ) u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (rom_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      addr_q  <= '0;
      cnt_q   <= '0;
      send_q  <= 1'b0;
      reg_q   <= 8'h00;
      val_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      send_q  <= send_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    send_d  = send_q;
    reg_d   = reg_q;
    val_d   = val_q;
    done_d  = done_q;
    advance = 1'b0;

    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (rom_data == CFG_END) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (rom_data == CFG_DELAY) begin
          cnt_d   = DELAY_LOAD;
          state_d = ST_DELAY;
        end else begin
          reg_d   = rom_data[15:8];
          val_d   = rom_data[7:0];
          send_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (taken) begin
          send_d  = 1'b0;
          advance = 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        send_d = 1'b0;
        if (resend) begin
          addr_d  = '0;
          done_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    // A table without an END marker stops at its last entry rather than replaying.
    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
    end
  end

  assign send        = send_q;
  assign id          = CAM_ID;
  assign register    = reg_q;
  assign value       = val_q;
  assign config_done = done_q;
  assign entry_idx   = addr_q;

endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// Self-checking bench for ov7670_config_ctrl: stub tables plus the production table,
// checked against a table-walking timing model with randomized taken latency and noise.
module tb_ov7670_config_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       taken_v  [4];
  logic       resend_v [4];
  logic       send_v   [4];
  logic [7:0] id_v     [4];
  logic [7:0] reg_v    [4];
  logic [7:0] val_v    [4];
  logic       done_v   [4];
  logic [7:0] idx_v    [4];
  logic [1:0] idx0, idx1, idx2;
  logic [7:0] idx3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ov7670_config_ctrl #(.ROM_DEPTH(4), .TABLE_SEL(1)) dut0 (
    .clk(clk), .reset(reset), .resend(resend_v[0]), .taken(taken_v[0]), .send(send_v[0]),
    .id(id_v[0]), .register(reg_v[0]), .value(val_v[0]), .config_done(done_v[0]), .entry_idx(idx0));
  ov7670_config_ctrl #(.ROM_DEPTH(4), .DELAY_CYCLES(100), .TABLE_SEL(2)) dut1 (
    .clk(clk), .reset(reset), .resend(resend_v[1]), .taken(taken_v[1]), .send(send_v[1]),
    .id(id_v[1]), .register(reg_v[1]), .value(val_v[1]), .config_done(done_v[1]), .entry_idx(idx1));
  ov7670_config_ctrl #(.ROM_DEPTH(4), .TABLE_SEL(3)) dut2 (
    .clk(clk), .reset(reset), .resend(resend_v[2]), .taken(taken_v[2]), .send(send_v[2]),
    .id(id_v[2]), .register(reg_v[2]), .value(val_v[2]), .config_done(done_v[2]), .entry_idx(idx2));
  ov7670_config_ctrl dut3 (
    .clk(clk), .reset(reset), .resend(resend_v[3]), .taken(taken_v[3]), .send(send_v[3]),
    .id(id_v[3]), .register(reg_v[3]), .value(val_v[3]), .config_done(done_v[3]), .entry_idx(idx3));

  assign idx_v[0] = 8'(idx0);
  assign idx_v[1] = 8'(idx1);
  assign idx_v[2] = 8'(idx2);
  assign idx_v[3] = idx3;

  // Bench copy of the stub tables and their pause lengths
  logic [15:0] tab [3][4];
  int          dcy [3];

  typedef struct {
    bit         is_done;
    logic [7:0] r;
    logic [7:0] v;
    int         gap;
    int         idx;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    int sel;
    int lat;
    bit noise;
    int exp_writes;
    int exp_idx;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      taken_v[i]  = 1'b0;
      resend_v[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Expected event list: each fetch+decode costs 2 cycles, a pause adds its length,
  // writes restart timing at the taken edge, the last address ends the walk.
  task automatic build_model(input int sel);
    int   gap;
    ev_t  e;
    exp_q.delete();
    gap = 0;
    for (int i = 0; i < 4; i++) begin
      gap += 2;
      if (tab[sel][i] == 16'hFFFF) begin
        e = '{1'b1, 8'h00, 8'h00, gap, i};
        exp_q.push_back(e);
        return;
      end
      if (tab[sel][i] == 16'hFFF0) begin
        gap += dcy[sel];
      end else begin
        e = '{1'b0, tab[sel][i][15:8], tab[sel][i][7:0], gap, i};
        exp_q.push_back(e);
        gap = 0;
      end
      if (i == 3) begin
        e = '{1'b1, 8'h00, 8'h00, gap, i};
        exp_q.push_back(e);
      end
    end
  endtask

  // Timing reference edge is the edge just before the call (reset release, resend or taken).
  task automatic run_seq(input int sel, input int lat, input bit noise, output int nw, output int fi);
    int         n, waited, hold;
    logic [7:0] r0, v0, i0;
    bit         bad;
    build_model(sel);
    n  = 0;
    nw = 0;
    fi = -1;
    foreach (exp_q[k]) begin
      waited = 0;
      if (!exp_q[k].is_done) begin
        while (send_v[sel] !== 1'b1 && waited < exp_q[k].gap + 10) begin
          if (noise && $urandom_range(0, 2) == 0) taken_v[sel] = 1'b1;
          if (noise && $urandom_range(0, 2) == 0) resend_v[sel] = 1'b1;
          step();
          n++;
          waited++;
        end
        chk("send_rise", 32'(send_v[sel]), 32'd1);
        chk("write_gap", 32'(n), 32'(exp_q[k].gap));
        chk("register", 32'(reg_v[sel]), 32'(exp_q[k].r));
        chk("value", 32'(val_v[sel]), 32'(exp_q[k].v));
        chk("id", 32'(id_v[sel]), 32'h42);
        chk("write_idx", 32'(idx_v[sel]), 32'(exp_q[k].idx));
        hold = (lat < 0) ? int'($urandom_range(0, 12)) : lat;
        r0 = reg_v[sel];
        v0 = val_v[sel];
        i0 = idx_v[sel];
        bad = 1'b0;
        for (int c = 0; c < hold; c++) begin
          if (noise && $urandom_range(0, 2) == 0) resend_v[sel] = 1'b1;
          step();
          if (send_v[sel] !== 1'b1 || reg_v[sel] !== r0 || val_v[sel] !== v0 || idx_v[sel] !== i0)
            bad = 1'b1;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        taken_v[sel] = 1'b1;
        step();
        n = 0;
        nw++;
        chk("send_drop", 32'(send_v[sel]), 32'd0);
      end else begin
        while (done_v[sel] !== 1'b1 && waited < exp_q[k].gap + 10) begin
          if (noise && $urandom_range(0, 2) == 0) taken_v[sel] = 1'b1;
          step();
          n++;
          waited++;
        end
        chk("done_rise", 32'(done_v[sel]), 32'd1);
        chk("done_gap", 32'(n), 32'(exp_q[k].gap));
        chk("send_low_done", 32'(send_v[sel]), 32'd0);
        chk("done_idx", 32'(idx_v[sel]), 32'(exp_q[k].idx));
        fi = int'(idx_v[sel]);
      end
    end
  endtask

  initial begin
    int         nw, fi, n;
    bit         bad;
    logic [7:0] r0, v0, i0;

    for (int i = 0; i < 4; i++) begin
      taken_v[i]  = 1'b0;
      resend_v[i] = 1'b0;
    end
    tab[0] = '{16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF};
    tab[1] = '{16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF};
    tab[2] = '{16'h1280, 16'h1204, 16'h1100, 16'h1300};
    dcy    = '{25000, 100, 25000};
    vecs[0] = '{0,  5, 1'b0, 2, 2};
    vecs[1] = '{0, -1, 1'b1, 2, 2};
    vecs[2] = '{1,  5, 1'b0, 2, 3};
    vecs[3] = '{1, -1, 1'b1, 2, 3};
    vecs[4] = '{2,  0, 1'b0, 4, 3};
    vecs[5] = '{2, -1, 1'b1, 4, 3};

    // Values held during reset
    step();
    chk("rst_send", 32'(send_v[0]), 32'd0);
    chk("rst_regval", {16'h0, reg_v[0], val_v[0]}, 32'h0);
    chk("rst_done_idx", {23'h0, done_v[0], idx_v[0]}, 32'h0);
    chk("rst_id", 32'(id_v[0]), 32'h42);

    foreach (vecs[t]) begin
      do_reset();
      run_seq(vecs[t].sel, vecs[t].lat, vecs[t].noise, nw, fi);
      chk("vec_writes", 32'(nw), 32'(vecs[t].exp_writes));
      chk("vec_final_idx", 32'(fi), 32'(vecs[t].exp_idx));
      bad = 1'b0;
      i0 = idx_v[vecs[t].sel];
      for (int c = 0; c < 20; c++) begin
        taken_v[vecs[t].sel] = 1'b1;
        step();
        if (send_v[vecs[t].sel] !== 1'b0 || done_v[vecs[t].sel] !== 1'b1 || idx_v[vecs[t].sel] !== i0)
          bad = 1'b1;
      end
      chk("done_sticky", 32'(bad), 32'd0);
    end

    // Sender stalled: request and payload stay put for 10k cycles
    do_reset();
    n = 0;
    while (send_v[0] !== 1'b1 && n < 12) begin step(); n++; end
    r0 = reg_v[0];
    v0 = val_v[0];
    i0 = idx_v[0];
    bad = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      step();
      if (send_v[0] !== 1'b1 || reg_v[0] !== r0 || val_v[0] !== v0 || idx_v[0] !== i0) bad = 1'b1;
    end
    chk("stall_10k", 32'(bad), 32'd0);
    chk("stall_payload", {16'h0, r0, v0}, 32'h1280);

    // Replay on resend from DONE
    do_reset();
    run_seq(0, 3, 1'b0, nw, fi);
    resend_v[0] = 1'b1;
    step();
    chk("resend_fall", 32'(done_v[0]), 32'd0);
    run_seq(0, 4, 1'b1, nw, fi);
    chk("replay_writes", 32'(nw), 32'd2);

    // Asynchronous reset while a write is pending
    do_reset();
    n = 0;
    while (send_v[0] !== 1'b1 && n < 12) begin step(); n++; end
    chk("pre_reset_send", 32'(send_v[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_send", 32'(send_v[0]), 32'd0);
    chk("async_reset_state", {15'h0, done_v[0], reg_v[0], val_v[0]}, 32'h0);
    step();
    reset = 1'b0;
    run_seq(0, 2, 1'b0, nw, fi);
    chk("post_reset_writes", 32'(nw), 32'd2);

    // Production table: soft reset first, then the post-reset pause
    do_reset();
    n = 0;
    while (send_v[3] !== 1'b1 && n < 12) begin step(); n++; end
    chk("prod_gap", 32'(n), 32'd2);
    chk("prod_first", {id_v[3], reg_v[3], val_v[3]}, 32'h421280);
    taken_v[3] = 1'b1;
    step();
    bad = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (send_v[3] !== 1'b0) bad = 1'b1;
    end
    chk("prod_pause", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
